m_src_fifo: RTL and testbench

M_SRC_FIFO -- requirements
Module: m_src_fifo

---
 rtl/m_src_fifo.sv | 144 ++++++++++++++
 tb/tb_m_src_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_src_fifo.sv
// m_src_fifo: first-word-fall-through source FIFO feeding the encode/decode
// engines. Each entry holds 64 data bits plus a stream "last" flag.
//
// Ports
//   wb_clk_i            single clock, rising edge
//   wb_rst_n            asynchronous active-low reset (deassertion synchronised)
//   flush               synchronous clear of contents, pointers and sticky flags
//   wr_en/wr_data/wr_last   push side (wr_en active-high)
//   wr_full, wr_almost_full, level   push-side status, level = occupancy
//   m_src_getn          pop request, active-low (X/Z treated as no pop)
//   m_src, m_src_last   head entry (forced to 0 while empty)
//   m_src_empty, m_src_almost_empty  pop-side status
//   ovf, unf            sticky push-while-full / pop-while-empty
//   pop_cnt, stream_cnt only when M_SRC_FIFO_STATS_EN is defined: accepted
//                       pops and accepted pops of a last-flagged word
//
// Handshake: a push is accepted on an edge where wr_en=1 and wr_full=0; a pop
// is accepted on an edge where m_src_getn=0 and m_src_empty=0. All status
// flags derive from registered state only, so neither request has a
// combinational path to any flag. flush overrides both requests.
//
// Optional feature macro: M_SRC_FIFO_STATS_EN (adds pop_cnt / stream_cnt).
module m_src_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AE_TH      = 1,
  parameter int AF_TH      = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [63:0]           wr_data,
  input  logic                  wr_last,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  m_src_getn,
  output logic [63:0]           m_src,
  output logic                  m_src_last,
  output logic                  m_src_empty,
  output logic                  m_src_almost_empty,
  output logic                  ovf,
  output logic                  unf
`ifdef M_SRC_FIFO_STATS_EN
  ,
  output logic [31:0]           pop_cnt,
  output logic [15:0]           stream_cnt
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [64:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [1:0]            rst_sync;
  logic                  ready;
  logic                  pop_req;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  push_rej;
  logic                  pop_rej;

  // Reset asserts asynchronously but releases through two flops, so the
  // request logic stays disabled for the first two edges after deassertion.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign ready = rst_sync[1];

  // Only a solid 0 requests a pop: an X/Z condition falls into the else arm,
  // so a floating pull-up bus in simulation never pops.
  always_comb begin
    pop_req = 1'b0;
    if (m_src_getn == 1'b0) pop_req = 1'b1;
    else                    pop_req = 1'b0;
  end

  assign wr_full            = (level == FULL_LVL);
  assign m_src_empty        = (level == '0);
  assign m_src_almost_empty = (int'(level) <= AE_TH);
  assign wr_almost_full     = ((DEPTH - int'(level)) <= AF_TH);

  assign push_ok  = ready && !flush && wr_en && !wr_full;
  assign pop_ok   = ready && !flush && pop_req && !m_src_empty;
  assign push_rej = ready && !flush && wr_en && wr_full;
  assign pop_rej  = ready && !flush && pop_req && m_src_empty;

  // Head is presented straight from storage; forced to zero while empty so
  // the output is stable and matches the reset value.
  assign m_src      = m_src_empty ? 64'd0 : mem[rd_ptr][63:0];
  assign m_src_last = m_src_empty ? 1'b0  : mem[rd_ptr][64];

  // Storage is not reset: pointers and level alone define what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= {wr_last, wr_data};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (push_rej) ovf <= 1'b1;
      if (pop_rej)  unf <= 1'b1;
    end
  end

`ifdef M_SRC_FIFO_STATS_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pop_cnt    <= 32'd0;
      stream_cnt <= 16'd0;
    end else if (flush) begin
      pop_cnt    <= 32'd0;
      stream_cnt <= 16'd0;
    end else if (pop_ok) begin
      pop_cnt <= pop_cnt + 32'd1;
      if (m_src_last) stream_cnt <= stream_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_src_fifo.sv
// Testbench for m_src_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_m_src_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int AE_TH      = 1;
  localparam int AF_TH      = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic        m_src_getn = 1'b1;
  logic        wr_full, wr_almost_full, m_src_last, m_src_empty, m_src_almost_empty;
  logic        ovf, unf;
  logic [DEPTH_LOG2:0] level;
  logic [63:0] m_src;
`ifdef M_SRC_FIFO_STATS_EN
  logic [31:0] pop_cnt;
  logic [15:0] stream_cnt;
`endif

  m_src_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .AE_TH(AE_TH), .AF_TH(AF_TH)) dut (
    .wb_clk_i(clk),
    .wb_rst_n(rst_n),
    .flush(flush),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_last(wr_last),
    .wr_full(wr_full),
    .wr_almost_full(wr_almost_full),
    .level(level),
    .m_src_getn(m_src_getn),
    .m_src(m_src),
    .m_src_last(m_src_last),
    .m_src_empty(m_src_empty),
    .m_src_almost_empty(m_src_almost_empty),
    .ovf(ovf),
    .unf(unf)
`ifdef M_SRC_FIFO_STATS_EN
    ,
    .pop_cnt(pop_cnt),
    .stream_cnt(stream_cnt)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  logic [64:0] exp_q[$];   // {last, data}, oldest at index 0
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  int          m_pops = 0;
  int          m_streams = 0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_pops = 0;
    m_streams = 0;
  endtask

  // Compare every observable against the model's current contents.
  task automatic compare_all();
    int n;
    n = exp_q.size();
    check("level", 64'(level), 64'(n));
    check("empty", 64'(m_src_empty), 64'(n == 0));
    check("full", 64'(wr_full), 64'(n == DEPTH));
    check("almost_empty", 64'(m_src_almost_empty), 64'(n <= AE_TH));
    check("almost_full", 64'(wr_almost_full), 64'((DEPTH - n) <= AF_TH));
    check("ovf", 64'(ovf), 64'(m_ovf));
    check("unf", 64'(unf), 64'(m_unf));
    if (n > 0) begin
      check("head_data", m_src, exp_q[0][63:0]);
      check("head_last", 64'(m_src_last), 64'(exp_q[0][64]));
    end
`ifdef M_SRC_FIFO_STATS_EN
    check("pop_cnt", 64'(pop_cnt), 64'(m_pops));
    check("stream_cnt", 64'(stream_cnt), 64'(m_streams & 16'hFFFF));
`endif
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of requests, advance the model by the rules of one edge,
  // then check shortly after the edge.
  task automatic step(input logic we, input logic [63:0] wd, input logic wl,
                      input logic getn, input logic fl);
    logic [64:0] head;
    bit full_b, empty_b;
    wr_en = we; wr_data = wd; wr_last = wl; m_src_getn = getn; flush = fl;
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      full_b  = (exp_q.size() == DEPTH);
      empty_b = (exp_q.size() == 0);
      if (we && full_b)     m_ovf = 1'b1;
      if (!getn && empty_b) m_unf = 1'b1;
      if (!getn && !empty_b) begin
        head = exp_q.pop_front();
        m_pops++;
        if (head[64]) m_streams++;
      end
      if (we && !full_b) exp_q.push_back({wl, wd});
    end
    #1;
    wr_en = 1'b0; m_src_getn = 1'b1; flush = 1'b0; wr_last = 1'b0;
    compare_all();
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    step(1'b1, d, l, 1'b1, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Release reset one step after an edge, then let the synchroniser settle.
  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    idle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset values while reset is held.
    #12;
    check("rst_level", 64'(level), 64'd0);
    check("rst_empty", 64'(m_src_empty), 64'd1);
    check("rst_ae", 64'(m_src_almost_empty), 64'd1);
    check("rst_full", 64'(wr_full), 64'd0);
    check("rst_af", 64'(wr_almost_full), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_unf", 64'(unf), 64'd0);
    check("rst_m_src", m_src, 64'd0);
    check("rst_last", 64'(m_src_last), 64'd0);

    // A push on the first edge after deassertion must not be taken.
    @(posedge clk);
    #1 rst_n = 1'b1; wr_en = 1'b1; wr_data = 64'h55;
    @(posedge clk);
    #1 check("sync_first_edge", 64'(level), 64'd0);
    wr_en = 1'b0;
    idle();
    idle();

    // Fill 0x1..0x10.
    for (int i = 1; i <= DEPTH; i++) push(64'(i), 1'b0);
    check("fill_full", 64'(wr_full), 64'd1);
    check("fill_head", m_src, 64'h1);

    // Overflow on full: rejected, sticky ovf.
    push(64'hDEAD, 1'b0);
    check("ovf_set", 64'(ovf), 64'd1);
    check("ovf_level", 64'(level), 64'd16);

    // Push+pop on full: push rejected, pop proceeds.
    step(1'b1, 64'hAA, 1'b0, 1'b0, 1'b0);
    check("full_pp_level", 64'(level), 64'd15);

    // Down to 8, then push+pop keeps level.
    for (int i = 0; i < 7; i++) pop();
    step(1'b1, 64'hAA, 1'b0, 1'b0, 1'b0);
    check("mid_pp_level", 64'(level), 64'd8);

    // Drain, then pop on empty.
    while (exp_q.size() > 0) pop();
    pop();
    check("unf_set", 64'(unf), 64'd1);

    // Flush clears sticky flags; then level 1 / level 2 flags.
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    push(64'h11, 1'b0);
    check("l1_ae", 64'(m_src_almost_empty), 64'd1);
    check("l1_empty", 64'(m_src_empty), 64'd0);
    push(64'h22, 1'b0);
    check("l2_ae", 64'(m_src_almost_empty), 64'd0);
    while (exp_q.size() > 0) pop();

    // Last flag on the third word of a stream.
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    push(64'h100, 1'b0);
    push(64'h200, 1'b0);
    push(64'h300, 1'b1);
    pop();
    pop();
    check("last_on_third", 64'(m_src_last), 64'd1);
    pop();
`ifdef M_SRC_FIFO_STATS_EN
    check("stats_pops", 64'(pop_cnt), 64'd3);
    check("stats_streams", 64'(stream_cnt), 64'd1);
`endif

    // Randomized traffic: push-heavy phase then pop-heavy phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 400; i++) begin
        logic we, getn, fl;
        we   = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        getn = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        fl   = ($urandom_range(0, 79) == 0);
        step(we, {$urandom, $urandom}, 1'($urandom_range(0, 1)), getn, fl);
      end
    end

    // Asynchronous reset mid-stream at level 5.
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) push(64'(32'h5000 + i), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("async_empty", 64'(m_src_empty), 64'd1);
    check("async_level", 64'(level), 64'd0);
    check("async_m_src", m_src, 64'd0);
    model_reset();
    release_reset();

    // Flush with a simultaneous push, after setting both sticky flags.
    pop();
    for (int i = 0; i < DEPTH + 1; i++) push(64'(32'h7000 + i), 1'b0);
    check("pre_flush_ovf", 64'(ovf), 64'd1);
    check("pre_flush_unf", 64'(unf), 64'd1);
    step(1'b1, 64'hBEEF, 1'b1, 1'b0, 1'b1);
    check("flush_level", 64'(level), 64'd0);
    check("flush_ovf", 64'(ovf), 64'd0);
    check("flush_unf", 64'(unf), 64'd0);
    push(64'h77, 1'b0);
    check("post_flush_head", m_src, 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
